svga_timing_gen: RTL



---
 rtl/svga_timing_gen_if.sv | 49 ++++
 rtl/svga_timing_gen.sv | 131 +++++++++++++
 2 files changed

// File: rtl/svga_timing_gen_if.sv
// Raster-scan bundle between the SVGA timing generator, the renderer and the VGA pins.
// The master side is the timing generator; the slave side is the renderer/connector.
interface svga_timing_gen_if;
  logic [10:0] h_coord;
  logic [9:0]  v_coord;
  logic        display_on;
  logic        frame_start;
  logic [15:0] frame_cnt;
  logic [3:0]  rgb_r_in;
  logic [3:0]  rgb_g_in;
  logic [3:0]  rgb_b_in;
  logic        vga_hs;
  logic        vga_vs;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;

  modport master (
    output h_coord,
    output v_coord,
    output display_on,
    output frame_start,
    output frame_cnt,
    input  rgb_r_in,
    input  rgb_g_in,
    input  rgb_b_in,
    output vga_hs,
    output vga_vs,
    output vga_r,
    output vga_g,
    output vga_b
  );

  modport slave (
    input  h_coord,
    input  v_coord,
    input  display_on,
    input  frame_start,
    input  frame_cnt,
    output rgb_r_in,
    output rgb_g_in,
    output rgb_b_in,
    input  vga_hs,
    input  vga_vs,
    input  vga_r,
    input  vga_g,
    input  vga_b
  );
endinterface

// File: rtl/svga_timing_gen.sv
// SVGA raster timing: free-running h/v counters, frame markers, and a PIPE-deep
// output register carrying sync and blanked renderer colour to the VGA pins.
module svga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 72,
  parameter int unsigned H_BP     = 128,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 22,
  parameter bit          H_POL    = 1'b1,
  parameter bit          V_POL    = 1'b1,
  parameter int unsigned PIPE     = 1
) (
  input logic               pixel_clk,
  input logic               rst_n,
  svga_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HMax     = 11'(H_TOTAL - 1);
  localparam logic [10:0] HActive  = 11'(H_ACTIVE);
  localparam logic [10:0] HsStart  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HsEnd    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VMax     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VActive  = 10'(V_ACTIVE);
  localparam logic [9:0]  VsStart  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VsEnd    = 10'(V_ACTIVE + V_FP + V_SYNC);

  if (PIPE < 1 || PIPE > 4) begin : gen_bad_pipe
    $error("svga_timing_gen: PIPE must be in 1..4");
  end
  if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : gen_bad_total
    $error("svga_timing_gen: totals exceed counter width");
  end

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pix_t;

  localparam pix_t PixRst = '{hs: ~H_POL, vs: ~V_POL, r: 4'h0, g: 4'h0, b: 4'h0};

  logic [10:0] h_q;
  logic [9:0]  v_q;
  logic        frame_start_q;
  logic [15:0] frame_cnt_q;
  logic [15:0] frame_cnt_d;
  pix_t        pipe_q [PIPE];

  logic        h_wrap;
  logic        v_wrap;
  logic        display_on;
  logic        hs_raw;
  logic        vs_raw;
  pix_t        stage_in;

  always_comb begin
    h_wrap     = (h_q == HMax);
    v_wrap     = (v_q == VMax);
    display_on = (h_q < HActive) && (v_q < VActive);
    hs_raw     = ((h_q >= HsStart) && (h_q < HsEnd)) ? H_POL : ~H_POL;
    vs_raw     = ((v_q >= VsStart) && (v_q < VsEnd)) ? V_POL : ~V_POL;
  end

  always_comb begin
    stage_in    = PixRst;
    stage_in.hs = hs_raw;
    stage_in.vs = vs_raw;
    if (display_on) begin
      stage_in.r = bus.rgb_r_in;
      stage_in.g = bus.rgb_g_in;
      stage_in.b = bus.rgb_b_in;
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (h_wrap && v_wrap) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      h_q           <= 11'd0;
      v_q           <= 10'd0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
    end else begin
      h_q           <= h_wrap ? 11'd0 : h_q + 11'd1;
      if (h_wrap) begin
        v_q <= v_wrap ? 10'd0 : v_q + 10'd1;
      end
      // Registered so the pulse coincides with the counters sitting at (0,0).
      frame_start_q <= h_wrap && v_wrap;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PIPE; i++) begin
        pipe_q[i] <= PixRst;
      end
    end else begin
      pipe_q[0] <= stage_in;
      for (int unsigned i = 1; i < PIPE; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign bus.h_coord     = h_q;
  assign bus.v_coord     = v_q;
  assign bus.display_on  = display_on;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.vga_hs      = pipe_q[PIPE-1].hs;
  assign bus.vga_vs      = pipe_q[PIPE-1].vs;
  assign bus.vga_r       = pipe_q[PIPE-1].r;
  assign bus.vga_g       = pipe_q[PIPE-1].g;
  assign bus.vga_b       = pipe_q[PIPE-1].b;

endmodule
